ps2_key_tracker: RTL
====================

# ps2_key_tracker

Parametrised PS/2 Set-2 scan-code tracker that sits between `PS2_Controller` and the game logic. It consumes the controller's received-byte stream and decodes the make, break and extended (E0) prefixes. It tracks the held state of NUM_KEYS configurable keys and emits one-cycle key events. It also derives the 2-bit `accel` command from keys 0 and 1. Unlike a last-byte latch, it releases a key on key-up, supports extended keys and several simultaneous keys, filters repeats, and recovers from truncated sequences.

## Interface
- NUM_KEYS, 4: number of tracked keys, 2..16.
- KEY_CODES, {9'h174, 9'h16B, 9'h072, 9'h073}: NUM_KEYS×9-bit table.
  - Key i occupies bits [9i+8:9i].
  - Bit 8 is the extended (E0) flag; bits 7:0 are the scan code.
  - Defaults: key0 = KP5, key1 = KP2, key2 = E0 6B, key3 = E0 74.
- REPEAT_EVENTS, 0: 1 pulses `key_event` on typematic repeats of a held key; 0 suppresses them.
- TIMEOUT_CYCLES, 2_500_000: idle cycles after a prefix byte before the FSM abandons the sequence (50 ms at 50 MHz).
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- received_data  in  8  byte from `PS2_Controller`.
- received_data_en  in  1  one-cycle strobe; `received_data` is valid when high.
- key_held  out  NUM_KEYS  bit i high while key i is down.
- key_event  out  1  one-cycle pulse on a make or break of a tracked key.
- event_index  out  $clog2(NUM_KEYS)  index of the key for the current `key_event`.
- event_make  out  1  1 = press, 0 = release; qualified by `key_event`.
- accel  out  2  2'b10 when only key0 is held, 2'b01 when only key1 is held, 2'b00 otherwise.
- seq_error  out  1  one-cycle pulse when a prefix sequence times out.

## Operation
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (E1 pause sequence).
- Transitions, all taken on `received_data_en`:
  - E0: from IDLE → EXT; from any other non-SKIP state → EXT (restarts the sequence).
  - F0: IDLE → BRK, EXT → EXT_BRK; BRK and EXT_BRK hold their state.
  - E1 in IDLE → SKIP with skip counter = 7. In SKIP, each byte decrements the counter; SKIP → IDLE on the byte that makes the count 0.
  - Any other byte is a terminal code:
    - Form the lookup {ext, code}; ext = 1 in EXT or EXT_BRK.
    - Match it against KEY_CODES. The lowest matching index wins.
    - Return to IDLE.
- Terminal in IDLE or EXT (make), matched key i:
  - If key_held[i] = 0: set it, pulse `key_event`, event_make = 1.
  - If already held: the pulse depends on REPEAT_EVENTS; key_held is unchanged.
- Terminal in BRK or EXT_BRK (break), matched key i:
  - If key_held[i] = 1: clear it, pulse `key_event`, event_make = 0.
  - A break of a key that is not held produces no event.
- Unmatched terminal: no event; the FSM returns to IDLE.
- In IDLE, bytes AA (BAT pass) and FA (ack) are ignored, and the FSM stays in IDLE.
- Timeout:
  - The counter resets on every strobe and counts only in EXT, BRK, EXT_BRK and SKIP.
  - When it reaches TIMEOUT_CYCLES−1: go to IDLE, pulse `seq_error`, leave key_held unchanged.
- `accel` is combinational from the key_held register only.
- Reset values:
  - FSM IDLE; key_held all 0; key_event, event_index, event_make and seq_error all 0; accel 2'b00.
  - Counters cleared.
  - Reset mid-sequence discards any partial prefix.

## Timing
- Strobe at cycle t → key_held, key_event, event_index and event_make all update at t+1. `accel` reflects the new key_held at t+1.
- key_event and seq_error are high for exactly one cycle.
- event_index and event_make hold their values between events.
- Strobes are at least 2 cycles apart (guaranteed by `PS2_Controller`). No back-pressure.
- Reset asserted together with a strobe: reset wins, and the byte is dropped.
- A timeout and a strobe in the same cycle: the strobe wins, the byte is processed in the current state, and there is no seq_error.

## Structure
- Package `ps2_key_pkg` holds:
  - byte constants PREFIX_EXT = 8'hE0, PREFIX_BRK = 8'hF0, PREFIX_PAUSE = 8'hE1, BYTE_BAT = 8'hAA, BYTE_ACK = 8'hFA;
  - the FSM state enum;
  - PAUSE_SKIP = 7;
  - ACCEL_FWD = 2'b10, ACCEL_REV = 2'b01, ACCEL_NONE = 2'b00.
- Sub-module `ps2_code_match`: combinational. Compares a 9-bit {ext, code} with KEY_CODES and returns hit plus the lowest-index match. It is parametrised by NUM_KEYS.

## Test plan
- Reset, then 73, then F0 73 → key_held = 4'b0001 and accel = 10 after 73. After the F0 73 break: key_held = 0, accel = 00, and two events (index 0, make 1, then make 0).
- 73, 72 held together → accel = 00. Then F0 73 → accel = 01.
- E0 6B, then 6B, then E0 F0 6B:
  - E0 6B → key2 make event.
  - Plain 6B → no event.
  - E0 F0 6B → key2 break event; key_held = 0.
- 73 sent five times with REPEAT_EVENTS = 0 → exactly 1 event. The same stimulus with REPEAT_EVENTS = 1 → 5 events; key_held[0] stays 1.
- E0 followed by silence for TIMEOUT_CYCLES (bench sets it to 100) → seq_error pulses once, then 72 → key1 make event (not extended).
- E1 14 77 E1 F0 14 F0 77, then 73 → no events and no state change during the 8-byte pause sequence; key0 make on the 73. Separately, reset asserted between F0 and 73 → the 73 is treated as a make.

Source files
------------

// File: rtl/ps2_key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_pkg
// Purpose  : Shared constants and FSM state encoding for the PS/2 key tracker.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_key_pkg;

    localparam logic [7:0] PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PREFIX_BRK   = 8'hF0;
    localparam logic [7:0] PREFIX_PAUSE = 8'hE1;
    localparam logic [7:0] BYTE_BAT     = 8'hAA;
    localparam logic [7:0] BYTE_ACK     = 8'hFA;

    // Bytes that follow the E1 that opens the Pause key sequence.
    localparam int PAUSE_SKIP = 7;

    localparam logic [1:0] ACCEL_FWD  = 2'b10;
    localparam logic [1:0] ACCEL_REV  = 2'b01;
    localparam logic [1:0] ACCEL_NONE = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } ps2_state_e;

endpackage : ps2_key_pkg
`default_nettype wire

// File: rtl/ps2_code_match.sv
`default_nettype none
// ============================================================================
// Module   : ps2_code_match
// Purpose  : Combinational lookup of a 9-bit {ext, code} in the key table.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_code_match #(
    parameter int                      NUM_KEYS  = 4,
    parameter int                      IDX_W     = 2,
    parameter logic [NUM_KEYS*9-1:0]   KEY_CODES = '0
) (
    input  logic [8:0]       lookup_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] index_o
);

    // Scanning downward lets the lowest matching index overwrite the others.
    always_comb begin
        hit_o   = 1'b0;
        index_o = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[9*i +: 9] == lookup_i) begin
                hit_o   = 1'b1;
                index_o = IDX_W'(i);
            end
        end
    end

endmodule : ps2_code_match
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_tracker
// Purpose  : Decodes PS/2 Set-2 make/break/E0 sequences into held-key state,
//            one-cycle key events and an accel command.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_tracker
    import ps2_key_pkg::*;
#(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h174, 9'h16B, 9'h072, 9'h073},
    parameter int                    REPEAT_EVENTS  = 0,
    parameter int                    TIMEOUT_CYCLES = 2_500_000,
    localparam int                   IDX_W          = $clog2(NUM_KEYS)
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [7:0]          received_data,
    input  logic                received_data_en,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                key_event,
    output logic [IDX_W-1:0]    event_index,
    output logic                event_make,
    output logic [1:0]          accel,
    output logic                seq_error
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e          state_q, state_d;
    logic [2:0]          skip_q, skip_d;
    logic [TO_W-1:0]     tmo_q, tmo_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic                event_q, event_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic                make_q, make_d;
    logic                err_q, err_d;

    logic                is_ext;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;

    assign is_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

    ps2_code_match #(
        .NUM_KEYS  (NUM_KEYS),
        .IDX_W     (IDX_W),
        .KEY_CODES (KEY_CODES)
    ) u_match (
        .lookup_i ({is_ext, received_data}),
        .hit_o    (hit),
        .index_o  (hit_idx)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            tmo_q   <= '0;
            held_q  <= '0;
            event_q <= 1'b0;
            index_q <= '0;
            make_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            held_q  <= held_d;
            event_q <= event_d;
            index_q <= index_d;
            make_q  <= make_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        tmo_d   = tmo_q;
        held_d  = held_q;
        event_d = 1'b0;
        index_d = index_q;
        make_d  = make_q;
        err_d   = 1'b0;

        if (received_data_en) begin
            tmo_d = '0;
            if (state_q == ST_SKIP) begin
                skip_d = skip_q - 3'd1;
                if (skip_q == 3'd1) begin
                    state_d = ST_IDLE;
                end
            end else if (received_data == PREFIX_EXT) begin
                state_d = ST_EXT;
            end else if (received_data == PREFIX_BRK) begin
                if (state_q == ST_IDLE) begin
                    state_d = ST_BRK;
                end else if (state_q == ST_EXT) begin
                    state_d = ST_EXT_BRK;
                end
            end else if (state_q == ST_IDLE && received_data == PREFIX_PAUSE) begin
                state_d = ST_SKIP;
                skip_d  = 3'(PAUSE_SKIP);
            end else if (state_q == ST_IDLE &&
                         (received_data == BYTE_BAT || received_data == BYTE_ACK)) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_IDLE;
                if (hit) begin
                    if (state_q == ST_IDLE || state_q == ST_EXT) begin
                        if (!held_q[hit_idx]) begin
                            held_d[hit_idx] = 1'b1;
                            event_d = 1'b1;
                            index_d = hit_idx;
                            make_d  = 1'b1;
                        end else if (REPEAT_EVENTS != 0) begin
                            event_d = 1'b1;
                            index_d = hit_idx;
                            make_d  = 1'b1;
                        end
                    end else if (held_q[hit_idx]) begin
                        held_d[hit_idx] = 1'b0;
                        event_d = 1'b1;
                        index_d = hit_idx;
                        make_d  = 1'b0;
                    end
                end
            end
        end else if (state_q != ST_IDLE) begin
            // A stalled prefix is dropped without touching the held keys.
            if (tmo_q == TO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_comb begin
        accel = ACCEL_NONE;
        if (held_q[0] && !held_q[1]) begin
            accel = ACCEL_FWD;
        end else if (held_q[1] && !held_q[0]) begin
            accel = ACCEL_REV;
        end
    end

    assign key_held    = held_q;
    assign key_event   = event_q;
    assign event_index = index_q;
    assign event_make  = make_q;
    assign seq_error   = err_q;

endmodule : ps2_key_tracker
`default_nettype wire
